spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receiving end of the neuron spike line: samples the `spike` output of the LIF neuron every clock, counts spikes over a fixed observation window, and at each window boundary latches the count as a firing rate. The latched rate drives a 7-segment hex digit on the demo board and an 8-bit rate bus with a one-cycle valid strobe for downstream logic.

## Interface
- `WINDOW`, default 256: observation window length in clock cycles; legal range 2..65536.
- `WIN_W`, default 16: width of the window counter; must satisfy 2^WIN_W >= WINDOW.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `spike`  input  1  spike line from the neuron, sampled as a level; each high cycle is one spike.
- `en`  input  1  count enable; low freezes both the window counter and the spike counter.
- `clr`  input  1  synchronous clear of the window and spike counters; outputs are not affected.
- `rate`  output  8  spike count of the last completed window, saturated at 255.
- `rate_valid`  output  1  one-cycle strobe marking a new `rate` value.
- `segments`  output  7  active-high segments of the display digit, bit0 = a … bit6 = g.

## Operation
- Internal state: `win_cnt` (WIN_W bits, 0..WINDOW-1) and `spk_cnt` (8 bits, saturating).
- Cycle with `en`=1 and `clr`=0:
  - `win_cnt` < WINDOW-1: `win_cnt` += 1; `spk_cnt` += `spike`, held at 255 if already 255.
  - `win_cnt` = WINDOW-1 (last cycle of the window): the closing count is `spk_cnt` + `spike`, saturated at 255. It loads into `rate`, `rate_valid` pulses, `segments` updates, and `win_cnt` and `spk_cnt` return to 0. The spike sampled in this cycle belongs to the closing window, not the new one.
- `en`=0: counters hold, no strobe, and spikes are ignored.
- `clr`=1: `win_cnt` and `spk_cnt` go to 0 and no strobe is issued, including when `win_cnt` = WINDOW-1. `clr` takes priority over `en`. `rate` and `segments` keep their last values.
- Display digit: `rate` if `rate` <= 15, otherwise 15 (shows "F" as an overflow indication).
- Hex patterns (g..a, hex value), digits 0 through F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset, asynchronous while `rst_n`=0:
  - `win_cnt` = 0, `spk_cnt` = 0
  - `rate` = 0, `rate_valid` = 0
  - `segments` = 7'h3F (digit 0)
- Release of `rst_n` is synchronised externally. The first counted cycle is the first rising edge with `rst_n`=1 and `en`=1.
- With `en` held high, `rate_valid` rises on the edge after the WINDOW-th counted cycle. It is high for exactly 1 cycle, and the spacing between strobes is exactly WINDOW cycles.
- `rate` and `segments` change only on the same edge where `rate_valid` rises, and both are stable between strobes.
- Reset asserted mid-window discards the partial count. The next strobe comes WINDOW counted cycles after reset release.
- Cycles with `en` low stretch the window; each window still contains exactly WINDOW counted cycles.

## Test plan
- Reset check (bench WINDOW=16): drive `rst_n` low → `rate`=0, `rate_valid`=0, `segments`=7'h3F. Release, hold `spike`=0 and `en`=1 for 16 cycles → one strobe on cycle 16 with `rate`=0.
- Fixed rate (WINDOW=16): `spike` high every 4th cycle → every strobe gives `rate`=4, `segments`=7'h66, strobes 16 cycles apart.
- Boundary spike (WINDOW=16): single spike on cycle 16 only (`win_cnt`=15) → that window's `rate`=1; the following empty window gives `rate`=0.
- Saturation and overflow (WINDOW=300): `spike` held high → `rate`=255, `segments`=7'h71. Separately, WINDOW=16 with `spike` high → `rate`=16, `segments`=7'h71.
- Enable and clear (WINDOW=16): drop `en` for 5 cycles mid-window → strobe delayed by 5 cycles and the count excludes spikes in those cycles. Pulse `clr` at `win_cnt`=15 → no strobe, and the next strobe comes 16 cycles later.
- Reset mid-window: 10 spike cycles, then a 1-cycle `rst_n` low → outputs return to their reset values, and the next window counts from zero.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts sampled spikes over a fixed window of counted cycles and
// latches the saturated count as a rate, with a valid strobe and a 7-segment hex digit.
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned WIN_W  = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       spike_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [7:0] rate_o,
  output logic       rate_valid_o,
  output logic [6:0] segments_o
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]       spk_cnt_q, spk_cnt_d;
  logic [7:0]       rate_q, rate_d;
  logic             valid_q, valid_d;
  logic [6:0]       seg_q, seg_d;

  logic [8:0]       spk_sum;
  logic [7:0]       spk_sat;
  logic [3:0]       digit;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Saturating count including this cycle's spike; on the last cycle this is the closing count.
  assign spk_sum = {1'b0, spk_cnt_q} + {8'b0, spike_i};
  assign spk_sat = spk_sum[8] ? 8'hFF : spk_sum[7:0];
  assign digit   = (spk_sat > 8'd15) ? 4'hF : spk_sat[3:0];

  always_comb begin
    win_cnt_d = win_cnt_q;
    spk_cnt_d = spk_cnt_q;
    rate_d    = rate_q;
    seg_d     = seg_q;
    valid_d   = 1'b0;
    if (clr_i) begin
      win_cnt_d = '0;
      spk_cnt_d = '0;
    end else if (en_i) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d = '0;
        spk_cnt_d = '0;
        rate_d    = spk_sat;
        seg_d     = hex7(digit);
        valid_d   = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        spk_cnt_d = spk_sat;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt_q <= '0;
      spk_cnt_q <= '0;
      rate_q    <= '0;
      valid_q   <= 1'b0;
      seg_q     <= 7'h3F;
    end else begin
      win_cnt_q <= win_cnt_d;
      spk_cnt_q <= spk_cnt_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      seg_q     <= seg_d;
    end
  end

  assign rate_o       = rate_q;
  assign rate_valid_o = valid_q;
  assign segments_o   = seg_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: a cycle model predicts each strobe (cycle, rate, digit) as stimulus is driven;
// a monitor pops and compares on every strobe and checks hold/reset values in between.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spike = 1'b0, en = 1'b0, clr = 1'b0;
  logic [7:0] rate;
  logic       rate_valid;
  logic [6:0] segments;

  logic       sat_spike = 1'b1, sat_en = 1'b1, sat_clr = 1'b0;
  logic [7:0] sat_rate;
  logic       sat_valid;
  logic [6:0] sat_seg;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(16), .WIN_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .spike_i(spike), .en_i(en), .clr_i(clr),
    .rate_o(rate), .rate_valid_o(rate_valid), .segments_o(segments)
  );

  spike_rate_decoder #(.WINDOW(300), .WIN_W(9)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .spike_i(sat_spike), .en_i(sat_en), .clr_i(sat_clr),
    .rate_o(sat_rate), .rate_valid_o(sat_valid), .segments_o(sat_seg)
  );

  typedef struct {int cyc; int rate; int seg;} exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int sat_cnt = 0, sat_strobes = 0;
  int m_win = 0, m_spk = 0;
  int seg_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                      'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int seg_of(input int r);
    return seg_tab[(r > 15) ? 15 : r];
  endfunction

  // One clock of stimulus; the model advances as the DUT will on the next rising edge.
  task automatic step(input bit sp, input bit e, input bit c);
    int s;
    @(negedge clk);
    spike = sp; en = e; clr = c;
    if (c) begin
      m_win = 0; m_spk = 0;
    end else if (e) begin
      s = m_spk + int'(sp);
      if (s > 255) s = 255;
      if (m_win == 15) begin
        q.push_back('{cyc + 1, s, seg_of(s)});
        m_win = 0; m_spk = 0;
      end else begin
        m_win++; m_spk = s;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; spike = 1'b0; en = 1'b0; clr = 1'b0;
    m_win = 0; m_spk = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    int last_rate, last_seg;
    exp_t e;
    last_rate = 0; last_seg = 'h3F;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) sat_cnt++;
      else sat_cnt = 0;
      #1;
      if (!rst_n) begin
        chk("rst_rate", rate, 0);
        chk("rst_valid", rate_valid, 0);
        chk("rst_seg", segments, 'h3F);
        last_rate = 0; last_seg = 'h3F;
      end else begin
        if (rate_valid) begin
          if (q.size() == 0) chk("spurious_strobe", rate_valid, 0);
          else begin
            e = q.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("rate", rate, e.rate);
            chk("segments", segments, e.seg);
            last_rate = e.rate; last_seg = e.seg;
          end
        end else begin
          if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("missed_strobe", rate_valid, 1);
            void'(q.pop_front());
          end
          chk("hold_rate", rate, last_rate);
          chk("hold_seg", segments, last_seg);
        end
        chk("sat_valid", sat_valid, int'(sat_cnt != 0 && sat_cnt % 300 == 0));
        if (sat_valid) begin
          sat_strobes++;
          chk("sat_rate", sat_rate, 255);
          chk("sat_seg", sat_seg, 'h71);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(0, 1, 0);
    for (int i = 0; i < 48; i++) step(i % 4 == 3, 1, 0);
    for (int i = 0; i < 32; i++) step(i == 15, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 0);

    // Disabled cycles carry spikes that must not be counted.
    for (int i = 0; i < 8; i++) step(i % 2, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(i % 2, 1, 0);

    for (int i = 0; i < 15; i++) step(1, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < 16; i++) step(i % 2, 1, 0);

    for (int i = 0; i < 10; i++) step(1, 1, 0);
    pulse_reset();
    for (int i = 0; i < 16; i++) step(i % 4 == 0, 1, 0);

    for (int i = 0; i < 330; i++)
      step(1'($urandom_range(1)), $urandom_range(9) != 0, $urandom_range(49) == 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    chk("queue_empty", q.size(), 0);
    chk("sat_seen", int'(sat_strobes > 0), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
